// File: rtl/tpu_loader.sv
// Packs a 32-bit host word stream into 32 A/B row pairs, then replays them to the TPU top
// as one contiguous burst and waits for top's output phase before refilling.
module tpu_loader #(
    parameter int WORD_W        = 32,
    parameter int ROW_W         = 256,
    parameter int WORDS_PER_ROW = 8,
    parameter int ROWS          = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              cfg_valid,
    input  logic [4:0]        cfg_m,
    input  logic [4:0]        cfg_n,
    input  logic [4:0]        cfg_k,
    output logic              in_valid,
    output logic [ROW_W-1:0]  gbuff_a,
    output logic [ROW_W-1:0]  gbuff_b,
    output logic [4:0]        m,
    output logic [4:0]        n,
    output logic [4:0]        k,
    input  logic              top_out_valid,
    output logic              busy
);

    // state   | meaning
    // S_FILL  | accepting host words into the A/B row store
    // S_BURST | presenting rows 0..ROWS-1 to top, one per cycle
    // S_WAIT  | waiting for top_out_valid to rise and then fall
    typedef enum logic [1:0] {S_FILL, S_BURST, S_WAIT} state_t;

    localparam int RW   = $clog2(ROWS);
    localparam int WW   = $clog2(2 * WORDS_PER_ROW);
    localparam int WSEL = $clog2(WORDS_PER_ROW);

    state_t          state, state_nx;
    logic [WW-1:0]   wc;
    logic [RW-1:0]   rc;
    logic            seen_high;
    logic [4:0]      sh_m, sh_n, sh_k;
    logic [ROW_W-1:0] mem_a [ROWS];
    logic [ROW_W-1:0] mem_b [ROWS];

    logic accept, last_row, last_word, tov_fall;

    assign accept    = s_valid && s_ready;
    assign last_row  = (rc == RW'(ROWS - 1));
    assign last_word = accept && last_row && (wc == WW'(2 * WORDS_PER_ROW - 1));
    assign tov_fall  = seen_high && !top_out_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FILL;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_FILL:  if (last_word) state_nx = S_BURST;
            S_BURST: if (last_row)  state_nx = S_WAIT;
            S_WAIT:  if (tov_fall)  state_nx = S_FILL;
            default: state_nx = S_FILL;
        endcase
    end

    // Row store is deliberately left out of reset; it is fully rewritten by each fill.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (!wc[WW-1])
                mem_a[rc][32'(wc[WSEL-1:0]) * WORD_W +: WORD_W] <= s_data;
            else
                mem_b[rc][32'(wc[WSEL-1:0]) * WORD_W +: WORD_W] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ready   <= 1'b0;
            in_valid  <= 1'b0;
            gbuff_a   <= '0;
            gbuff_b   <= '0;
            m         <= '0;
            n         <= '0;
            k         <= '0;
            busy      <= 1'b0;
            wc        <= '0;
            rc        <= '0;
            seen_high <= 1'b0;
            sh_m      <= '0;
            sh_n      <= '0;
            sh_k      <= '0;
        end else begin
            busy <= (state_nx != S_FILL);
            case (state)
                S_FILL: begin
                    s_ready <= !last_word;
                    if (cfg_valid) begin
                        sh_m <= cfg_m;
                        sh_n <= cfg_n;
                        sh_k <= cfg_k;
                    end
                    if (accept) begin
                        if (wc == WW'(2 * WORDS_PER_ROW - 1)) begin
                            wc <= '0;
                            rc <= last_row ? '0 : rc + 1'b1;
                        end else begin
                            wc <= wc + 1'b1;
                        end
                    end
                    // Row 0 goes out on the first burst cycle; a coincident cfg wins over the shadow.
                    if (last_word) begin
                        in_valid <= 1'b1;
                        gbuff_a  <= mem_a[0];
                        gbuff_b  <= mem_b[0];
                        m        <= cfg_valid ? cfg_m : sh_m;
                        n        <= cfg_valid ? cfg_n : sh_n;
                        k        <= cfg_valid ? cfg_k : sh_k;
                    end
                end
                S_BURST: begin
                    if (last_row) begin
                        in_valid  <= 1'b0;
                        gbuff_a   <= '0;
                        gbuff_b   <= '0;
                        rc        <= '0;
                        seen_high <= 1'b0;
                    end else begin
                        rc      <= rc + 1'b1;
                        gbuff_a <= mem_a[rc + 1'b1];
                        gbuff_b <= mem_b[rc + 1'b1];
                    end
                end
                S_WAIT: begin
                    if (top_out_valid) seen_high <= 1'b1;
                    if (tov_fall) begin
                        s_ready   <= 1'b1;
                        seen_high <= 1'b0;
                        rc        <= '0;
                        wc        <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_loader.sv
// Randomized bench for tpu_loader: host word fills, burst row contents/timing, cfg capture,
// top_out_valid handshake and mid-burst reset, all checked against a word-index model.
module tb_tpu_loader;

    logic         clk = 1'b0;
    logic         rst;
    logic         s_valid;
    logic         s_ready;
    logic [31:0]  s_data;
    logic         cfg_valid;
    logic [4:0]   cfg_m, cfg_n, cfg_k;
    logic         in_valid;
    logic [255:0] gbuff_a, gbuff_b;
    logic [4:0]   m, n, k;
    logic         top_out_valid;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] words [512];
    logic [4:0]  exp_m, exp_n, exp_k;

    tpu_loader dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .cfg_valid(cfg_valid), .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k),
        .in_valid(in_valid), .gbuff_a(gbuff_a), .gbuff_b(gbuff_b),
        .m(m), .n(n), .k(k),
        .top_out_valid(top_out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // Row r of A holds host words 16r..16r+7, row r of B holds 16r+8..16r+15, word 0 at LSB.
    function automatic logic [255:0] row_of(input int r, input bit is_b);
        logic [255:0] v;
        v = '0;
        for (int j = 0; j < 8; j++)
            v[32*j +: 32] = words[16*r + (is_b ? 8 : 0) + j];
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_pulse(input logic [4:0] pm, input logic [4:0] pn, input logic [4:0] pk);
        s_valid   = 1'b0;
        cfg_valid = 1'b1;
        cfg_m = pm; cfg_n = pn; cfg_k = pk;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic fill(input bit rand_valid, input bit cfg_last,
                        input logic [4:0] lm, input logic [4:0] ln, input logic [4:0] lk);
        int  idx = 0;
        int  cyc = 0;
        bit  acc;
        while (idx < 512 && cyc < 5000) begin
            s_valid   = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data    = words[idx];
            cfg_valid = cfg_last && idx == 511 && s_valid && s_ready;
            cfg_m = lm; cfg_n = ln; cfg_k = lk;
            acc = s_valid && s_ready;
            tick();
            cyc++;
            if (acc) idx++;
        end
        cfg_valid = 1'b0;
        s_valid   = 1'b1;
        s_data    = 32'hdead_beef;
        chk("fill_words_accepted", 256'(idx), 256'(512));
    endtask

    task automatic burst(input int abort_row);
        for (int r = 0; r < 32; r++) begin
            if (r == abort_row) begin
                s_valid = 1'b0;
                rst = 1'b1;
                #1;
                chk("rst_in_valid", 256'(in_valid), 256'(0));
                chk("rst_gbuff_a",  gbuff_a, 256'(0));
                chk("rst_gbuff_b",  gbuff_b, 256'(0));
                chk("rst_mnk",      256'({m, n, k}), 256'(0));
                chk("rst_busy",     256'(busy), 256'(0));
                chk("rst_s_ready",  256'(s_ready), 256'(0));
                return;
            end
            chk($sformatf("burst_in_valid_r%0d", r), 256'(in_valid), 256'(1));
            chk($sformatf("burst_a_r%0d", r), gbuff_a, row_of(r, 1'b0));
            chk($sformatf("burst_b_r%0d", r), gbuff_b, row_of(r, 1'b1));
            chk($sformatf("burst_mnk_r%0d", r), 256'({m, n, k}), 256'({exp_m, exp_n, exp_k}));
            chk($sformatf("burst_busy_ready_r%0d", r), 256'({busy, s_ready}), 256'(2'b10));
            tick();
        end
        chk("post_in_valid", 256'(in_valid), 256'(0));
        chk("post_gbuff",    256'(gbuff_a | gbuff_b), 256'(0));
        chk("post_busy",     256'(busy), 256'(1));
    endtask

    task automatic drain(input bit cfg_in_wait);
        top_out_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cfg_valid = cfg_in_wait && i == 4;
            cfg_m = 5'd3; cfg_n = 5'd3; cfg_k = 5'd3;
            tick();
        end
        cfg_valid = 1'b0;
        top_out_valid = 1'b1;
        for (int i = 0; i < 33; i++) begin
            if (i == 0 || i == 32)
                chk($sformatf("wait_busy_ready_%0d", i), 256'({busy, s_ready}), 256'(2'b10));
            tick();
        end
        top_out_valid = 1'b0;
        chk("fall_cycle_busy_ready", 256'({busy, s_ready}), 256'(2'b10));
        s_valid = 1'b0;
        tick();
        chk("after_fall_busy_ready", 256'({busy, s_ready}), 256'(2'b01));
        chk("after_fall_mnk", 256'({m, n, k}), 256'({exp_m, exp_n, exp_k}));
    endtask

    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_data = '0;
        cfg_valid = 1'b0; cfg_m = '0; cfg_n = '0; cfg_k = '0;
        top_out_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 256'({s_ready, in_valid, busy, m, n, k}), 256'(0));
        chk("reset_gbuff",   gbuff_a | gbuff_b, 256'(0));
        rst = 1'b0;
        tick();
        chk("fill_ready", 256'({busy, s_ready}), 256'(2'b01));

        // Index-valued words, steady valid.
        for (int i = 0; i < 512; i++) words[i] = 32'(i);
        cfg_pulse(5'd16, 5'd16, 5'd16);
        exp_m = 5'd16; exp_n = 5'd16; exp_k = 5'd16;
        fill(1'b0, 1'b0, '0, '0, '0);
        burst(-1);
        drain(1'b0);

        // Same data with random valid; second cfg coincides with the final word.
        cfg_pulse(5'd4, 5'd16, 5'd16);
        fill(1'b1, 1'b1, 5'd9, 5'd16, 5'd16);
        exp_m = 5'd9;
        burst(-1);
        drain(1'b1);

        // Random data; shadow still holds m=9. Reset at row 10.
        for (int i = 0; i < 512; i++) words[i] = $urandom;
        fill(1'b1, 1'b0, '0, '0, '0);
        burst(10);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("post_rst_ready", 256'({busy, s_ready}), 256'(2'b01));

        // Fresh fill after reset.
        for (int i = 0; i < 512; i++) words[i] = $urandom;
        cfg_pulse(5'd8, 5'd8, 5'd8);
        exp_m = 5'd8; exp_n = 5'd8; exp_k = 5'd8;
        fill(1'b1, 1'b0, '0, '0, '0);
        burst(-1);
        drain(1'b0);

        // Back-to-back set with random dims captured on the final word.
        for (int i = 0; i < 512; i++) words[i] = $urandom;
        exp_m = 5'($urandom); exp_n = 5'($urandom); exp_k = 5'($urandom);
        fill(1'b1, 1'b1, exp_m, exp_n, exp_k);
        burst(-1);
        drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tpu_loader.md
Name: tpu_loader

Overview:
- Upstream feeder for the TPU top block: accepts a narrow 32-bit host word stream and packs it into 256-bit A and B matrix rows.
- Buffers a complete 32-row operand set, then drives top's in_valid/gbuff_a/gbuff_b/m/n/k as one contiguous burst.
- Waits for top's output phase to finish before accepting the next operand set.

Parameters:
- WORD_W, 32, host word width.
- ROW_W, 256, matrix row width (must equal WORDS_PER_ROW*WORD_W).
- WORDS_PER_ROW, 8, host words per A row and per B row.
- ROWS, 32, rows per operand set (matches top global buffer depth).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- s_valid  in  1  host word valid.
- s_ready  out  1  loader can accept a host word.
- s_data  in  WORD_W  host word.
- cfg_valid  in  1  capture cfg_m/cfg_n/cfg_k this cycle.
- cfg_m, cfg_n, cfg_k  in  5 each  matrix dimensions for the next burst.
- in_valid  out  1  to top in_valid.
- gbuff_a  out  ROW_W  to top gbuff_a.
- gbuff_b  out  ROW_W  to top gbuff_b.
- m, n, k  out  5 each  to top m/n/k.
- top_out_valid  in  1  top out_valid, used for completion tracking.
- busy  out  1  high in BURST and WAIT.

Behaviour:
- Reset values: s_ready=0, in_valid=0, gbuff_a=0, gbuff_b=0, m=n=k=0, busy=0. State goes to FILL; word and row counters go to 0. Row storage is not cleared.
- Storage: two arrays of ROWS x ROW_W (A and B), plus a 4-bit word counter wc (0..15) and a 5-bit row counter rc.
- FILL state:
  - s_ready=1. A word is accepted on s_valid&&s_ready.
  - Word wc<8 is written to A[rc][32*wc+31:32*wc]; wc>=8 is written to B[rc][32*(wc-8)+31:...]. Word 0 is at the LSB.
  - On wc==15, wc wraps to 0 and rc increments.
  - The acceptance of word 16*ROWS-1 (rc==31, wc==15) moves the block to BURST next cycle. s_ready drops in the same cycle as the transition (registered).
  - cfg_valid in FILL latches cfg_m/n/k into shadow registers; the last capture wins. cfg_valid outside FILL is ignored.
- BURST state (entry cycle t0):
  - m/n/k outputs are loaded from the shadow registers at t0 and held constant until the next BURST.
  - in_valid=1 for exactly ROWS consecutive cycles t0..t0+31. Cycle t0+r presents gbuff_a=A[r], gbuff_b=B[r]. All outputs are registered.
  - At t0+32: in_valid=0, gbuff_a/gbuff_b=0, state moves to WAIT.
- WAIT state:
  - Waits for a top_out_valid rising edge, then its falling edge.
  - On the falling edge, the next cycle returns to FILL with rc=wc=0 and s_ready=1.
  - top_out_valid high on the cycle of WAIT entry counts as a rise.
- busy=1 in BURST and WAIT, 0 in FILL.
- Simultaneous cfg_valid and final-word acceptance in the same cycle: the cfg value is captured and used for this burst.
- s_valid while s_ready=0: ignored, data dropped. The host must hold the word.
- Reset asserted mid-FILL, BURST or WAIT: immediate return to reset values. A partial operand set is discarded and in_valid drops asynchronously.
- No data is reordered. A/B rows are delivered in row order 0..31 only.

Test Plan:
- Reset, then host sends 512 words with value = index (0..511), cfg m=n=k=16 -> burst row r gives gbuff_a word j = 16r+j and gbuff_b word j = 16r+8+j. in_valid is high exactly 32 cycles; m=n=k=16 throughout.
- Host toggles s_valid randomly (50%) during FILL -> identical burst contents. No word is accepted while s_ready=0 in BURST/WAIT.
- Drive top_out_valid high 33 cycles then low, 10 cycles after the burst ends -> busy falls and s_ready=1 exactly one cycle after the top_out_valid falling edge.
- Two cfg_valid pulses (m=4, then m=9), the second coincident with the final word -> burst m=9. A cfg_valid during WAIT (m=3) does not change m.
- Assert rst at burst row 10 -> in_valid=0 and outputs are 0 immediately. After release, a fresh 512-word fill produces a correct full 32-row burst.
- Connect to top with known A/B -> top gbuff_out matches the golden matmul for m=n=k=8, and a second back-to-back operand set is also correct.
